// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with level/pulse interrupt
//
// Purpose: countdown timer on the CPU peripheral bus. The CPU programs a
// preset value and a control word. The timer counts down from the preset and
// raises an interrupt flag when the count expires. It either stops (one-shot)
// or reloads and keeps running (auto-reload).
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous active-low reset
//   addr   in   2   register word offset (0 CTRL, 1 PRESET, 2 COUNT, 3 unused)
//   we     in   1   write strobe, already qualified by the bridge
//   din    in  32   write data
//   dout   out 32   combinational read data for addr
//   irq    out  1   interrupt request (irq_flag gated by CTRL.IM)

module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count, count_nxt;
  logic             irq_flag, irq_flag_nxt;

  logic ctrl_wr, preset_wr;
  logic flag_set, flag_clr, en_clr;

  assign ctrl_wr   = we && (addr == 2'd0);
  assign preset_wr = we && (addr == 2'd1);

  // Only MODE==1 reloads; 2 and 3 fall back to one-shot behaviour.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;
    en_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else if (count != '0) begin
          count_nxt = count - CNT_W'(1);
        end else begin
          state_nxt = S_INT;
          flag_set  = 1'b1;
        end
      end
      S_INT: begin
        if (mode == 2'd1) begin
          state_nxt = S_LOAD;
          flag_clr  = 1'b1;
        end else begin
          en_clr    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A CTRL or PRESET write acknowledges the interrupt, but an expiry on the
  // same edge still wins so that an interrupt is never silently lost.
  always_comb begin
    irq_flag_nxt = irq_flag;
    if (flag_set)
      irq_flag_nxt = 1'b1;
    else if (flag_clr || ctrl_wr || preset_wr)
      irq_flag_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      en       <= 1'b0;
      mode     <= 2'd0;
      im       <= 1'b0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      irq_flag <= irq_flag_nxt;
      // CPU write to CTRL takes priority over the one-shot auto-clear of EN.
      if (ctrl_wr) begin
        en   <= din[0];
        mode <= din[2:1];
        im   <= din[3];
      end else if (en_clr) begin
        en <= 1'b0;
      end
      if (preset_wr)
        preset <= din[CNT_W-1:0];
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout[3:0]       = {im, mode, en};
      2'd1:    dout[CNT_W-1:0] = preset;
      2'd2:    dout[CNT_W-1:0] = count;
      default: dout            = '0;
    endcase
  end

  assign irq = irq_flag & im;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - directed and randomized checks of timer_dev
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_dev #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  // Reference timeline, edge k counted from the edge that wrote EN=1.
  // Each run: edge 1 loads, edges 2..N+2 show N..0, edge N+3 expires.
  // Auto-reload repeats that with period N+3.
  function automatic logic [31:0] exp_count(input int n, input bit auto_r, input int k);
    int p;
    if (!auto_r) begin
      if (k <= n + 2) return 32'(n - (k - 2));
      return 32'd0;
    end
    p = (k - 1) % (n + 3);
    if (p >= 1 && p <= n + 1) return 32'(n - (p - 1));
    return 32'd0;
  endfunction

  function automatic logic exp_irq(input int n, input bit auto_r, input int k);
    if (!auto_r) return (k >= n + 3);
    return ((k - 1) % (n + 3)) == (n + 2);
  endfunction

  logic [31:0] r, c0, d;
  int n, m;
  bit ar;

  initial begin
    // Reset state
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, r); check("rst_ctrl", r, 32'd0);
    rd(2'd1, r); check("rst_preset", r, 32'd0);
    rd(2'd2, r); check("rst_count", r, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    rd(2'd2, r); check("idle_count", r, 32'd0);

    // One-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) begin rd(2'd2, r); check("os_count_n", r, 32'd5); end
      if (k == 7) begin rd(2'd2, r); check("os_count_0", r, 32'd0); end
      check($sformatf("os_irq_e%0d", k), {31'd0, irq}, {31'd0, (k >= 8)});
    end
    rd(2'd0, r); check("os_ctrl_after", r, 32'h8);
    wr(2'd0, 32'h8);
    check("os_irq_cleared", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3: pulses at edges 6, 12, 18
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 19; k++) begin
      tick();
      check($sformatf("ar_irq_e%0d", k), {31'd0, irq}, {31'd0, exp_irq(3, 1'b1, k)});
      if (k >= 2) begin
        rd(2'd2, r);
        check($sformatf("ar_count_e%0d", k), r, exp_count(3, 1'b1, k));
      end
    end
    wr(2'd0, 32'h0);
    repeat (4) tick();

    // Masked one-shot: flag set internally but irq stays low
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("mask_irq_e%0d", k), {31'd0, irq}, 32'd0);
    end
    wr(2'd0, 32'h8);
    tick();
    check("unmask_irq", {31'd0, irq}, 32'd0);

    // PRESET write acknowledges a pending one-shot interrupt
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    repeat (5) tick();
    check("pclr_irq_high", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'd6);
    check("pclr_irq_low", {31'd0, irq}, 32'd0);
    rd(2'd0, r); check("pclr_ctrl", r, 32'h8);

    // Pause and preset update
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 12; k++) tick();
    rd(2'd2, r); check("pause_at10", r, 32'd10);
    wr(2'd1, 32'd4);            // edge 13, count 9
    wr(2'd0, 32'h0);            // edge 14, count 8, EN drops
    tick();
    rd(2'd2, r); check("pause_frozen_a", r, 32'd8);
    tick();
    rd(2'd2, r); check("pause_frozen_b", r, 32'd8);
    wr(2'd0, 32'h9);
    tick();
    rd(2'd2, r); check("resume_load_edge", r, 32'd8);
    tick();
    rd(2'd2, r); check("resume_reloaded", r, 32'd4);
    wr(2'd0, 32'h9);            // EN=1 while counting must not restart
    tick();
    rd(2'd2, r); check("no_restart", r, 32'd2);
    wr(2'd0, 32'h0);
    repeat (3) tick();

    // Bus edges
    rd(2'd2, c0);
    wr(2'd2, 32'hDEAD_BEEF);
    rd(2'd2, r); check("count_ro", r, c0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, r); check("addr3_zero", r, 32'd0);
    rd(2'd0, r); check("addr3_ctrl", r, 32'h0);
    rd(2'd1, r); check("addr3_preset", r, 32'd4);

    // PRESET=0 one-shot: irq at edge 3
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("p0_irq_e%0d", k), {31'd0, irq}, {31'd0, (k >= 3)});
    end

    // Random register readback
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      wr(2'd1, d);
      rd(2'd1, r); check("rnd_preset_rb", r, d);
      d = $urandom;
      wr(2'd0, d & 32'hFFFF_FFFE);
      rd(2'd0, r); check("rnd_ctrl_rb", r, d & 32'hE);
    end

    // Random runs against the reference timeline
    for (int it = 0; it < 6; it++) begin
      n  = $urandom_range(0, 12);
      m  = $urandom_range(0, 3);
      ar = (m == 1);
      wr(2'd0, 32'h0);
      repeat (4) tick();
      wr(2'd1, 32'(n));
      wr(2'd0, {28'd0, 1'b1, 2'(m), 1'b1});
      for (int k = 1; k <= 3 * (n + 3) + 1; k++) begin
        tick();
        check($sformatf("rnd%0d_irq_e%0d", it, k), {31'd0, irq}, {31'd0, exp_irq(n, ar, k)});
        if (k >= 2) begin
          rd(2'd2, r);
          check($sformatf("rnd%0d_count_e%0d", it, k), r, exp_count(n, ar, k));
        end
      end
      if (!ar) begin
        rd(2'd0, r);
        check($sformatf("rnd%0d_ctrl", it), r, {28'd0, 1'b1, 2'(m), 1'b0});
      end
    end

    // Asynchronous reset while irq is high mid auto-reload
    wr(2'd0, 32'h0);
    repeat (4) tick();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    repeat (6) tick();
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, r); check("async_reset_ctrl", r, 32'd0);
    rd(2'd1, r); check("async_reset_preset", r, 32'd0);
    rd(2'd2, r); check("async_reset_count", r, 32'd0);
    reset = 1'b1;
    repeat (4) tick();
    rd(2'd2, r); check("post_reset_count", r, 32'd0);
    check("post_reset_irq", {31'd0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer on the CPU's peripheral bus, directly downstream of the CPU core.
- Consumes the CPU's peripheral address, write data and write-enable through the system bridge.
- Returns read data that the bridge muxes onto the CPU's peripheral read-data input.
- Drives one hardware interrupt line that lands on one bit of HWInt[7:2]; the CP0 handler clears it by a register write.

Parameters:
- CNT_W, 32, width of PRESET and COUNT registers (must be ≤ 32)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- addr  in  2  word offset, taken from peripheral address bits [3:2]; bridge qualifies the base address
- we  in  1  write strobe, already qualified by the bridge (the CPU suppresses it when an interrupt is taken)
- din  in  32  write data
- dout  out  32  combinational read data for the current addr
- irq  out  1  interrupt request to HWInt

Behaviour:
- Register map:
  - addr 0: CTRL, read/write. Bit 0 is EN, bits [2:1] are MODE, bit 3 is IM (interrupt mask). Bits [31:4] read as 0.
  - addr 1: PRESET, read/write.
  - addr 2: COUNT, read-only; writes are ignored.
  - addr 3: reads 0; writes are ignored.
- Widths: CNT_W registers are zero-extended on read; a write keeps din[CNT_W-1:0].
- MODE: 0 = one-shot, 1 = auto-reload. MODE values 2 and 3 behave as 0 but read back as written.
- Reset (reset low): state IDLE; CTRL=0, PRESET=0, COUNT=0, irq_flag=0. Therefore irq=0 and dout=0 for CTRL reads. Reset mid-count abandons the count, with no pending interrupt.
- FSM, registered, one transition per edge:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT ← PRESET; go to CNT.
  - CNT: if EN=0, go to IDLE with COUNT held. Else if COUNT≠0, COUNT ← COUNT−1. Else (COUNT=0) go to INT and set irq_flag=1 on the same edge.
  - INT: if MODE=1, go to LOAD and clear irq_flag on that edge, giving a 1-cycle pulse. Otherwise clear EN and go to IDLE, leaving irq_flag set (level interrupt).
- irq = irq_flag & IM, purely combinational from registers. Clearing IM masks the interrupt without clearing irq_flag.
- Clearing irq_flag in one-shot mode: any write to CTRL or PRESET clears it on that edge.
- Timing: with PRESET=N written beforehand and CTRL.EN written at edge 0:
  - LOAD at edge 1
  - COUNT=N at edge 2
  - COUNT=0 at edge 2+N
  - INT and irq_flag=1 at edge 3+N
  - Auto-reload period is N+3 cycles; PRESET=0 still gives a period of 3.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle the FSM clears EN (INT, one-shot): the CPU write wins; EN takes din[0].
  - A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
  - A write to CTRL with EN=0 during CNT: IDLE on the next edge, COUNT frozen. Re-enabling reloads from PRESET; there is no resume.
  - A write to CTRL with EN=1 while already counting does not restart the count.
- COUNT never wraps below 0; decrement only when COUNT≠0.
- dout is valid in the same cycle as addr, with no read side effects.

Test Plan:
- Reset: hold reset low mid-count with irq high → irq=0 immediately; after release, CTRL, PRESET and COUNT all read 0 and the state is IDLE.
- One-shot: write PRESET=5, then CTRL=0x9 at edge 0 → COUNT reads 5 at edge 2 and 0 at edge 7. irq rises at edge 8 and stays high. CTRL then reads 0x8. Writing CTRL=0x8 drops irq on the next edge.
- Auto-reload: write PRESET=3, then CTRL=0xB → irq is a 1-cycle pulse at edges 6, 12 and 18. COUNT sequence is 3,2,1,0 repeating.
- Mask: one-shot with CTRL=0x1 (IM=0), PRESET=2 → irq stays 0. Writing IM=1 via CTRL=0x8 then clears irq_flag, so irq stays 0. Verify that a masked-then-unmasked write without touching CTRL (PRESET write) also clears irq_flag.
- Pause and preset update: during CNT at COUNT=10, write PRESET=4, then CTRL=0x0 → COUNT freezes at its current value. Writing CTRL=0x9 reloads COUNT to 4 two edges later, not to the frozen value.
- Bus edges: a write to addr 2 leaves COUNT unchanged; a write to addr 3 has no effect and reads 0. With PRESET=0 in one-shot mode, irq rises at edge 3 after enable.
